// File: rtl/instruction_fetch_unit.sv
// Prefetching instruction fetcher: streams i_count words from instruction RAM into a DEPTH-entry buffer.
// Optional feature macro FETCH_SKIP_NOOP_EN: all-zero returned words are dropped instead of buffered.
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH  = 10,
    parameter int INSTR_WIDTH = 33,
    parameter int DEPTH       = 4
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_start_addr,
    input  logic [ADDR_WIDTH:0]    i_count,
    output logic                   o_mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic [INSTR_WIDTH-1:0] i_mem_rd_data,
    output logic                   o_instr_valid,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    input  logic                   i_instr_ready,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH:0]    remaining;
    logic                   inflight;
    logic [INSTR_WIDTH-1:0] buffer [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [OCC_W-1:0]       occ;
    logic [OCC_W-1:0]       occ_next;
    logic [OCC_W:0]         used;
    logic                   rd_en;
    logic                   push;
    logic                   pop;
    logic                   done;

    // Credit counts the outstanding read but deliberately not a same-cycle pop.
    assign used  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign rd_en = (state == RUN) && (remaining != '0) && (used < DEPTH_L);
    assign pop   = o_instr_valid && i_instr_ready;

`ifdef FETCH_SKIP_NOOP_EN
    assign push = inflight && (i_mem_rd_data != '0);
`else
    assign push = inflight;
`endif

    always_comb begin
        occ_next = occ;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_W'(1);
            2'b01:   occ_next = occ - OCC_W'(1);
            default: occ_next = occ;
        endcase
    end

    assign o_mem_rd_en   = rd_en;
    assign o_mem_addr    = rd_en ? pc : '0;
    assign o_instr_valid = (occ != '0);
    assign o_instruction = o_instr_valid ? buffer[rd_ptr] : '0;
    assign o_busy        = (state != IDLE);
    assign o_done        = done;

    always_ff @(posedge i_clock) begin
        if (push && !i_reset) begin
            buffer[wr_ptr] <= i_mem_rd_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= IDLE;
            pc        <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            done      <= 1'b0;
        end else begin
            inflight <= rd_en;
            occ      <= occ_next;
            done     <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                pc        <= pc + ADDR_WIDTH'(1);
                remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            pc        <= i_start_addr;
                            remaining <= i_count;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_en && remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Look ahead one edge so o_done is a registered pulse in the first idle cycle.
                    if (!rd_en && occ_next == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: queue-based reference model checked every cycle, plus directed scenarios.
// Honours FETCH_SKIP_NOOP_EN the same way the design does.
module tb_instruction_fetch_unit;
    localparam int AW = 10;
    localparam int IW = 33;
    localparam int D  = 4;
`ifdef FETCH_SKIP_NOOP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [IW-1:0] rd_data;
    logic          valid;
    logic [IW-1:0] instr;
    logic          ready;
    logic          busy;
    logic          done;

    logic [IW-1:0] mem [1024];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    // reference model state
    bit            m_busy;
    bit            m_inflight;
    bit            m_done;
    int            m_pc;
    int            m_rem;
    int            m_inf_addr;
    logic [IW-1:0] m_fifo [$];

    // event logs for directed checks
    int            rd_cyc [$];
    int            rd_addr [$];
    int            acc_cyc [$];
    logic [IW-1:0] acc_word [$];
    int            done_cyc [$];
    int            busy_cnt;

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_start_addr  (start_addr),
        .i_count       (count),
        .o_mem_rd_en   (rd_en),
        .o_mem_addr    (addr),
        .i_mem_rd_data (rd_data),
        .o_instr_valid (valid),
        .o_instruction (instr),
        .i_instr_ready (ready),
        .o_busy        (busy),
        .o_done        (done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_data <= rd_en ? mem[addr] : {1'($urandom), $urandom};
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        bit exp_rd;
        exp_rd = m_busy && (m_rem > 0) && ((m_fifo.size() + int'(m_inflight)) < D);
        if (armed) begin
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) chk("mem_addr", addr, m_pc);
            chk("instr_valid", valid, m_fifo.size() > 0);
            if (m_fifo.size() > 0) chk("instruction", instr, m_fifo[0]);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
        end
        if (rd_en) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(addr));
        end
        if (valid && ready) begin
            acc_cyc.push_back(cyc);
            acc_word.push_back(instr);
        end
        if (done) done_cyc.push_back(cyc);
        if (busy) busy_cnt++;

        if (rst) begin
            armed      = 1'b1;
            m_busy     = 1'b0;
            m_inflight = 1'b0;
            m_done     = 1'b0;
            m_pc       = 0;
            m_rem      = 0;
            m_fifo.delete();
        end else if (armed) begin
            if (m_fifo.size() > 0 && ready) void'(m_fifo.pop_front());
            if (m_inflight && (!SKIP || mem[m_inf_addr] != '0)) m_fifo.push_back(mem[m_inf_addr]);
            m_inflight = exp_rd;
            if (exp_rd) begin
                m_inf_addr = m_pc;
                m_pc       = (m_pc + 1) % 1024;
                m_rem      = m_rem - 1;
            end
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    if (count == '0) begin
                        m_done = 1'b1;
                    end else begin
                        m_busy = 1'b1;
                        m_pc   = int'(start_addr);
                        m_rem  = int'(count);
                    end
                end
            end else if (m_rem == 0 && !m_inflight && m_fifo.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_cyc.delete();
        rd_addr.delete();
        acc_cyc.delete();
        acc_word.delete();
        done_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic start_run(int a, int c);
        start_addr = AW'(a);
        count      = (AW + 1)'(c);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cyc.size() == 0) begin
            errors++;
            $display("FAIL wait_done: no o_done within %0d cycles (cycle %0d)", budget, cyc);
        end
    endtask

    task automatic scenario_basic(string tag);
        int t;
        ready = 1'b1;
        clear_logs();
        t = cyc;
        start_run(5, 3);
        wait_done(30);
        tick();
        tick();
        chk({tag, "_nreads"}, rd_cyc.size(), 3);
        for (int i = 0; i < rd_cyc.size() && i < 3; i++) begin
            chk({tag, "_rd_cycle"}, rd_cyc[i], t + 1 + i);
            chk({tag, "_rd_addr"}, rd_addr[i], 5 + i);
        end
        chk({tag, "_nacc"}, acc_cyc.size(), 3);
        for (int i = 0; i < acc_cyc.size() && i < 3; i++) begin
            chk({tag, "_acc_cycle"}, acc_cyc[i], t + 3 + i);
            chk({tag, "_acc_word"}, acc_word[i], mem[5 + i]);
        end
        chk({tag, "_ndone"}, done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk({tag, "_done_cycle"}, done_cyc[0], t + 6);
    endtask

    initial begin
        logic [IW-1:0] exp_words [$];
        logic [IW-1:0] word_a;
        logic [IW-1:0] word_b;
        int t;
        int n;

        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; ready = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = {1'b1, $urandom};
        tick();
        tick();
        rst = 1'b0;
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", rd_en, 0);

        // three-word run with ready held high
        scenario_basic("basic");

        // stall with ready low, then release
        ready = 1'b0;
        clear_logs();
        start_run(100, 8);
        repeat (10) tick();
        chk("stall_nreads", rd_cyc.size(), 4);
        chk("stall_valid", valid, 1);
        chk("stall_head", instr, mem[100]);
        repeat (3) tick();
        chk("stall_head_stable", instr, mem[100]);
        ready = 1'b1;
        wait_done(40);
        tick();
        chk("stall_nreads_total", rd_cyc.size(), 8);
        chk("stall_nacc", acc_word.size(), 8);
        for (int i = 0; i < acc_word.size() && i < 8; i++) chk("stall_word", acc_word[i], mem[100 + i]);

        // address wrap at the top of the RAM, full-rate delivery
        clear_logs();
        t = cyc;
        start_run(1022, 4);
        wait_done(30);
        tick();
        chk("wrap_nreads", rd_cyc.size(), 4);
        exp_words = {mem[1022], mem[1023], mem[0], mem[1]};
        for (int i = 0; i < rd_addr.size() && i < 4; i++) begin
            chk("wrap_addr", rd_addr[i], (1022 + i) % 1024);
            chk("wrap_word", acc_word[i], exp_words[i]);
            chk("wrap_acc_cycle", acc_cyc[i], t + 3 + i);
        end

        // zero-length run
        clear_logs();
        t = cyc;
        start_run(7, 0);
        repeat (3) tick();
        chk("zero_nreads", rd_cyc.size(), 0);
        chk("zero_ndone", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk("zero_done_cycle", done_cyc[0], t + 1);
        chk("zero_busy_le1", busy_cnt <= 1, 1);

        // reset with one read outstanding and two words buffered
        ready = 1'b0;
        clear_logs();
        start_run(200, 8);
        repeat (3) tick();
        chk("rst_pre_nreads", rd_cyc.size(), 3);
        chk("rst_pre_valid", valid, 1);
        chk("rst_pre_head", instr, mem[200]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_addr", addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) tick();
        chk("rst_dropped_valid", valid, 0);
        chk("rst_no_done", done_cyc.size(), 0);
        scenario_basic("after_reset");

        // NOOP words in the stream
        word_a = 33'h1_2345_6789;
        word_b = 33'h0_0BAD_F00D;
        mem[300] = word_a; mem[301] = '0; mem[302] = word_b; mem[303] = '0;
        ready = 1'b1;
        clear_logs();
        start_run(300, 4);
        wait_done(30);
        tick();
        if (SKIP) exp_words = {word_a, word_b};
        else      exp_words = {word_a, 33'h0, word_b, 33'h0};
        chk("noop_nreads", rd_cyc.size(), 4);
        chk("noop_nacc", acc_word.size(), exp_words.size());
        for (int i = 0; i < acc_word.size() && i < exp_words.size(); i++) chk("noop_word", acc_word[i], exp_words[i]);
        chk("noop_ndone", done_cyc.size(), 1);

        // randomized traffic against the model
        for (int i = 0; i < 1024; i++) mem[i] = ($urandom_range(0, 3) == 0) ? '0 : {1'($urandom), $urandom};
        for (int c = 0; c < 4000; c++) begin
            start      = ($urandom_range(0, 3) == 0);
            start_addr = AW'($urandom);
            count      = (AW + 1)'($urandom_range(0, 12));
            ready      = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
        ready = 1'b1;
        n = 0;
        while (m_busy && n < 100) begin
            tick();
            n++;
        end
        repeat (2) tick();
        chk("final_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, the instruction-memory word address width.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 33, the instruction word width (op_code plus rd, rs_1 and rs_2).
REQ-003 The block SHALL have parameter DEPTH, default 4, the prefetch buffer entry count (power of 2, at least 2).
REQ-004 The block SHALL have port i_clock, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_start, input, 1 bit: starts a fetch run; sampled only in IDLE.
REQ-007 The block SHALL have port i_start_addr, input, ADDR_WIDTH bits: the first instruction address.
REQ-008 The block SHALL have port i_count, input, ADDR_WIDTH+1 bits: the number of words to fetch.
REQ-009 The block SHALL have port o_mem_rd_en, output, 1 bit: instruction RAM read strobe.
REQ-010 The block SHALL have port o_mem_addr, output, ADDR_WIDTH bits: instruction RAM read address.
REQ-011 The block SHALL have port i_mem_rd_data, input, INSTR_WIDTH bits: RAM read data, valid exactly 1 cycle after o_mem_rd_en.
REQ-012 The block SHALL have port o_instr_valid, output, 1 bit: o_instruction holds a fetched word.
REQ-013 The block SHALL have port o_instruction, output, INSTR_WIDTH bits: the instruction to the processor, taken from the buffer head.
REQ-014 The block SHALL have port i_instr_ready, input, 1 bit: the processor accepts o_instruction.
REQ-015 The block SHALL have port o_busy, output, 1 bit: high when state is not IDLE.
REQ-016 The block SHALL have port o_done, output, 1 bit: a one-cycle pulse when a run completes.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 In IDLE, i_start=1 SHALL capture address and count, then go to RUN, or go straight to IDLE with o_done=1 next cycle when i_count=0.
REQ-019 i_start SHALL be ignored while in RUN or DRAIN.
REQ-020 In RUN, o_mem_rd_en SHALL assert when remaining>0 and occupancy+inflight<DEPTH, ignoring any same-cycle pop.
REQ-021 Each read SHALL drive o_mem_addr=PC, then increment PC modulo 2^ADDR_WIDTH (1023 wraps to 0) and decrement remaining.
REQ-022 Read data SHALL be written to the buffer at the end of the cycle after the read; inflight is at most 1.
REQ-023 RUN SHALL go to DRAIN in the cycle the last read issues.
REQ-024 DRAIN SHALL go to IDLE once inflight=0 and the buffer is empty, with o_done=1 for exactly that cycle.
REQ-025 A transfer SHALL occur when o_instr_valid and i_instr_ready are both 1; words leave in fetch order.
REQ-026 o_instruction SHALL hold stable while o_instr_valid=1 and i_instr_ready=0.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged, including at occupancy 1, with no bubble.
REQ-028 The buffer SHALL never overflow: the credit rule guarantees it, and underflow is impossible because valid tracks non-empty.
REQ-029 Latency SHALL be: start sampled in cycle T, rd_en in T+1, data in T+2, o_instr_valid=1 in T+3.
REQ-030 With ready held at 1 and no stalls, sustained throughput SHALL be 1 instruction per cycle.

Reset
REQ-031 i_reset=1 SHALL force state=IDLE, PC=0, remaining=0, inflight=0, buffer empty, and all outputs 0.
REQ-032 Reset mid-run SHALL abort the run with no o_done pulse, and read data returning the next cycle SHALL be discarded.

Configuration
REQ-033 When macro FETCH_SKIP_NOOP_EN is defined, all-zero returned words (NOOP) SHALL NOT be enqueued, their credit is freed, and they still count toward i_count.
REQ-034 When FETCH_SKIP_NOOP_EN is undefined, all words SHALL be enqueued, NOOPs included.

Verification
REQ-035 The bench SHALL cover: start addr=5, count=3, ready=1 -> rd_en at T+1..T+3 with addr 5,6,7, valid at T+3..T+5 in order, o_done once at T+6.
REQ-036 The bench SHALL cover: count=8, ready=0 -> exactly 4 reads issued and then stall, valid held and o_instruction stable; ready=1 -> the remaining 4 fetched, 8 delivered, no loss or duplicate.
REQ-037 The bench SHALL cover: start addr=1022, count=4 -> addresses 1022,1023,0,1.
REQ-038 The bench SHALL cover: count=0 -> no rd_en, o_done pulse the next cycle, o_busy=1 for 1 cycle at most.
REQ-039 The bench SHALL cover: reset asserted with 1 read inflight and 2 buffered -> next cycle all outputs 0, returned data dropped, a new start behaves as the first scenario.
REQ-040 The bench SHALL cover: with FETCH_SKIP_NOOP_EN, count=4 and words {A,0,B,0} -> only A and B delivered, o_done still pulses; without the macro, 4 words delivered.
